// File: rtl/fifo_in_pkg.sv
// rtl/fifo_in_pkg.sv - shared sizing constants for the FIFO-in buffer
package fifo_in_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 16;
    localparam int ADDR_W         = $clog2(DEPTH_DEF);
    localparam int CNT_W          = ADDR_W + 1;

endpackage

// File: rtl/fifo_in_mem.sv
// rtl/fifo_in_mem.sv - DEPTH x DATA_WIDTH register array, one write port, async read
module fifo_in_mem
    import fifo_in_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the pushed word; contents are intentionally never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_in_buffer.sv
// rtl/fifo_in_buffer.sv - show-ahead FIFO between the bus write strobe and a ready/valid consumer
module fifo_in_buffer
    import fifo_in_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write,
    input  logic [DATA_WIDTH-1:0]  writedata,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   full,
    output logic [$clog2(DEPTH):0] usedw,
    output logic                   overflow,
    input  logic                   clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          full_q;
    logic          overflow_q;
    logic          push;
    logic          pop;
    logic          drop;

    // A write is judged against the registered full flag only, so a pop in
    // the same cycle never rescues a write that arrives while full.
    assign push = write & ~full_q;
    assign drop = write & full_q;
    assign pop  = (count != '0) & out_ready;

    // Next occupancy: +1 push only, -1 pop only, unchanged for both or neither
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and flags; full is registered from next occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count  <= count_nxt;
            full_q <= (count_nxt == CW'(DEPTH));
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    fifo_in_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~reset),
        .waddr (wr_ptr),
        .wdata (writedata),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    assign out_valid = (count != '0);
    assign full      = full_q;
    assign usedw     = count;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fifo_in_buffer.sv
// tb/tb_fifo_in_buffer.sv - directed vector table plus corner sequences and queue model for fifo_in_buffer
module tb_fifo_in_buffer;

    logic        clk;
    logic        reset;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        full;
    logic [4:0]  usedw;
    logic        overflow;
    logic        clear_overflow;

    int n_vec;
    int n_err;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [31:0] wd;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [31:0] e_data;
        logic [4:0]  e_usedw;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    fifo_in_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .write          (write),
        .writedata      (writedata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .full           (full),
        .usedw          (usedw),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [31:0] d,
                        input logic rd, input logic c);
        reset          = r;
        write          = w;
        writedata      = d;
        out_ready      = rd;
        clear_overflow = c;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        write          = 1'b0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [31:0] d,
                             input logic [4:0] u, input logic f, input logic o);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".usedw"}, {27'd0, usedw}, {27'd0, u});
        chk({tag, ".full"}, {31'd0, full}, {31'd0, f});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, o});
        if (v) chk({tag, ".out_data"}, out_data, d);
    endtask

    function automatic vec_t mk(logic rst, logic wr, logic [31:0] wd, logic rdy, logic clr,
                                logic ev, logic [31:0] ed, logic [4:0] eu, logic ef, logic eo);
        vec_t t;
        t.rst = rst; t.wr = wr; t.wd = wd; t.rdy = rdy; t.clr = clr;
        t.e_valid = ev; t.e_data = ed; t.e_usedw = eu; t.e_full = ef; t.e_ovf = eo;
        return t;
    endfunction

    int          mq[$];
    logic        m_ovf;
    logic        m_push;
    logic        m_pop;
    int          wp;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0; write = 1'b0; writedata = '0; out_ready = 1'b0; clear_overflow = 1'b0;

        // Reset state, single show-ahead push, fill to full, dropped write, drain in order, clear
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hA5A5_0001, 0, 0, 1, 32'hA5A5_0001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 1, i, 0, 0, 1, 0, 5'(i + 1), (i == 15), 0));
        vecs.push_back(mk(0, 1, 32'hDEAD, 0, 0, 1, 0, 16, 1, 1));
        for (int k = 0; k < 16; k++)
            vecs.push_back(mk(0, 0, 0, 1, 0, (k != 15), k + 1, 5'(15 - k), 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rdy, vecs[i].clr);
            chk_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                      vecs[i].e_usedw, vecs[i].e_full, vecs[i].e_ovf);
        end

        // Steady push+pop at half occupancy across the pointer wrap
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 100 + i, 0, 0);
        for (int c = 0; c < 20; c++) begin
            step(0, 1, 108 + c, 1, 0);
            chk_state($sformatf("stream%0d", c), 1, 101 + c, 8, 0, 0);
        end

        // Push+pop while full: pop happens, write dropped; set beats clear
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 200 + i, 0, 0);
        step(0, 1, 32'hBEEF, 1, 0);
        chk_state("full_pushpop", 1, 201, 15, 0, 1);
        step(0, 1, 32'h300, 0, 0);
        chk_state("refill", 1, 201, 16, 1, 1);
        step(0, 1, 32'hBAD, 0, 1);
        chk_state("set_wins", 1, 201, 16, 1, 1);
        step(0, 0, 0, 0, 1);
        chk_state("clear", 1, 201, 16, 1, 0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d", k), out_data, (k == 15) ? 32'h300 : 32'(201 + k));
            step(0, 0, 0, 1, 0);
        end
        chk_state("drained", 0, 0, 0, 0, 0);

        // Reset mid-transfer with overflow set, then a fresh push
        for (int i = 0; i < 17; i++) step(0, 1, 400 + i, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 0);
        chk_state("pre_reset", 1, 411, 5, 0, 1);
        step(1, 1, 32'h777, 1, 0);
        chk_state("mid_reset", 0, 0, 0, 0, 0);
        step(0, 1, 32'h1234, 0, 0);
        chk_state("post_reset", 1, 32'h1234, 1, 0, 0);

        // Random traffic against a reference queue
        step(1, 0, 0, 0, 0);
        mq.delete();
        m_ovf = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            wp = ((cyc / 400) % 2 == 0) ? 75 : 30;
            reset          = 1'b0;
            write          = ($urandom_range(0, 99) < wp);
            writedata      = $urandom;
            out_ready      = ($urandom_range(0, 99) < 50);
            clear_overflow = ($urandom_range(0, 99) < 5);
            chk("rnd.valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
            chk("rnd.usedw", {27'd0, usedw}, 32'(mq.size()));
            chk("rnd.full", {31'd0, full}, {31'd0, (mq.size() == 16)});
            chk("rnd.ovf", {31'd0, overflow}, {31'd0, m_ovf});
            if (mq.size() != 0) chk("rnd.data", out_data, mq[0]);
            m_push = write && (mq.size() != 16);
            m_pop  = out_ready && (mq.size() != 0);
            if (write && mq.size() == 16) m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(writedata);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
